// File: rtl/cordic_mmio_ctrl.sv
// cordic_mmio_ctrl: bus-mapped sequencer that launches the CORDIC core and captures its results
//
// Ports:
//   clk, reset                  single clock, synchronous active-high reset
//   mem_valid/addr/wdata/wstrb  PicoRV32 native-bus request (held until mem_ready)
//   mem_ready, mem_rdata        one-cycle acknowledge and read data (0 when not acknowledging)
//   sel                         combinational address-window hit for the interconnect read mux
//   core_start, core_angle      launch pulse and Q16.16 angle, angle held stable through WAIT
//   core_done, core_cos/sin     completion pulse and Q16.16 results
// Build option: CORDIC_CTRL_AUTOSTART_EN makes an idle INPUT_DATA write also launch the core.
module cordic_mmio_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'hF000_0000,
    parameter int          TIMEOUT   = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        sel,
    output logic        core_start,
    output logic [31:0] core_angle,
    input  logic        core_done,
    input  logic [31:0] core_cos,
    input  logic [31:0] core_sin
);
    typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT} state_t;

    state_t      state, state_n;
    logic [31:0] input_data, cos_q, sin_q, angle_sel, rd_mux;
    logic [15:0] cnt;
    logic [7:0]  off;
    logic        done, ovr, range_err, timeout;
    logic        busy, wr, w1c, ctrl_start, in_wr, start_req, in_range, is_res, acc;
    logic        cap, abort, timed_out;

    assign sel        = mem_addr[31:8] == BASE_ADDR[31:8];
    assign off        = mem_addr[7:0];
    assign busy       = state != ST_IDLE;
    // The CPU holds the request through the acknowledge cycle, so writes commit there;
    // this places a CTRL.start launch exactly one cycle after the acknowledge.
    assign wr         = mem_ready & mem_valid & sel & |mem_wstrb;
    assign w1c        = wr & (off == 8'h04);
    assign ctrl_start = wr & (off == 8'h00) & mem_wdata[0];
    assign in_wr      = wr & (off == 8'h18);
`ifdef CORDIC_CTRL_AUTOSTART_EN
    assign start_req  = ctrl_start | in_wr;
    assign angle_sel  = in_wr ? mem_wdata : input_data;
`else
    assign start_req  = ctrl_start;
    assign angle_sel  = input_data;
`endif
    assign in_range   = $signed(angle_sel) >= $signed(32'hFFA6_0000) && $signed(angle_sel) <= $signed(32'h005A_0000);
    assign timed_out  = cnt == 16'(TIMEOUT);
    assign cap        = (state == ST_WAIT) & core_done;
    assign abort      = (state == ST_WAIT) & ~core_done & timed_out;
    assign is_res     = ~|mem_wstrb & ((off == 8'h1C) | (off == 8'h20));
    // Result reads stall until the sequencer is about to be idle, so they ack with fresh data.
    assign acc        = ~mem_ready & mem_valid & sel & ~(is_res & (state_n != ST_IDLE));
    assign mem_rdata  = mem_ready ? rd_mux : 32'h0;

    always_comb begin
        state_n    = state;
        core_start = 1'b0;
        case (state)
            ST_IDLE:   state_n = (start_req && in_range) ? ST_LAUNCH : ST_IDLE;
            ST_LAUNCH: begin
                state_n    = ST_WAIT;
                core_start = 1'b1;
            end
            ST_WAIT:   state_n = (core_done || timed_out) ? ST_IDLE : ST_WAIT;
            default:   state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = 32'h0;
        case (off)
            8'h04:   rd_mux = {27'd0, timeout, range_err, ovr, done, busy};
            8'h18:   rd_mux = input_data;
            8'h1C:   rd_mux = cos_q;
            8'h20:   rd_mux = sin_q;
            default: rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            mem_ready  <= 1'b0;
            core_angle <= 32'h0;
            input_data <= 32'h0;
            cos_q      <= 32'h0;
            sin_q      <= 32'h0;
            cnt        <= 16'h0;
            done       <= 1'b0;
            ovr        <= 1'b0;
            range_err  <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state     <= state_n;
            mem_ready <= acc;
            cnt       <= state == ST_LAUNCH ? 16'd1 : state == ST_WAIT ? cnt + 16'd1 : 16'd0;
            if (in_wr && !busy)
                input_data <= mem_wdata;
            if (state == ST_IDLE && state_n == ST_LAUNCH)
                core_angle <= angle_sel;
            if (cap) begin
                cos_q <= core_cos;
                sin_q <= core_sin;
            end else if (abort) begin
                cos_q <= 32'hDEAD_BEEF;
                sin_q <= 32'hDEAD_BEEF;
            end
            // Hardware sets take priority over a same-cycle W1C.
            done      <= cap | (done & (state != ST_LAUNCH) & ~(w1c & mem_wdata[1]));
            ovr       <= (busy & (ctrl_start | in_wr)) | (ovr & ~(w1c & mem_wdata[2]));
            range_err <= (~busy & start_req & ~in_range) | (range_err & ~(w1c & mem_wdata[3]));
            timeout   <= abort | (timeout & ~(w1c & mem_wdata[4]));
        end
    end
endmodule

// File: tb/tb_cordic_mmio_ctrl.sv
// tb_cordic_mmio_ctrl: randomized self-checking bench with a register-level model and a CORDIC core stub
module tb_cordic_mmio_ctrl;
    localparam logic [31:0] BASE   = 32'hF000_0000;
    localparam int          TMO    = 64;
    localparam logic [31:0] A_CTRL = BASE;
    localparam logic [31:0] A_STAT = BASE + 32'h04;
    localparam logic [31:0] A_IN   = BASE + 32'h18;
    localparam logic [31:0] A_COS  = BASE + 32'h1C;
    localparam logic [31:0] A_SIN  = BASE + 32'h20;

    logic        clk = 1'b0, reset = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = 32'h0, mem_wdata = 32'h0;
    logic [3:0]  mem_wstrb = 4'h0;
    logic        mem_ready, sel, core_start;
    logic [31:0] mem_rdata, core_angle;
    logic        core_done = 1'b0;
    logic [31:0] core_cos = 32'h0, core_sin = 32'h0;

    int tests = 0, fails = 0, cyc = 0;
    logic [31:0] m_in = 0, m_cos = 0, m_sin = 0;
    bit m_done, m_ovr, m_rerr, m_to;

    int stub_delay = 20, timer = 0, starts = 0;
    logic [31:0] stub_cos = 0, stub_sin = 0;
    int ready_violations = 0;
    logic prev_ready = 1'b0;

    cordic_mmio_ctrl #(.BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .sel(sel), .core_start(core_start), .core_angle(core_angle),
        .core_done(core_done), .core_cos(core_cos), .core_sin(core_sin)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Core stub: done pulses stub_delay cycles after the start pulse; delay 0 never completes.
    always @(negedge clk) begin
        core_done = 1'b0;
        if (core_start) begin
            starts++;
            timer = stub_delay;
        end else if (timer > 0) begin
            timer--;
            if (timer == 0) begin
                core_done = 1'b1;
                core_cos  = stub_cos;
                core_sin  = stub_sin;
            end
        end
    end

    always @(negedge clk) begin
        if (mem_ready && prev_ready) ready_violations++;
        prev_ready = mem_ready;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
        $fatal(1);
    end

    function automatic bit in_range(input logic [31:0] a);
        int s;
        s = a;
        return s >= -90 * 65536 && s <= 90 * 65536;
    endfunction

    function automatic logic [31:0] rand_in();
        return 32'($urandom_range(0, 32'h00B4_0000)) - 32'h005A_0000;
    endfunction

    function automatic logic [31:0] exp_reg(input logic [7:0] off);
        case (off)
            8'h04:   return {27'd0, m_to, m_rerr, m_ovr, m_done, 1'b0};
            8'h18:   return m_in;
            8'h1C:   return m_cos;
            8'h20:   return m_sin;
            default: return 32'h0;
        endcase
    endfunction

    task automatic bus_access(input logic [31:0] addr, wdata, input logic [3:0] wstrb,
                              output logic [31:0] rdata, output int ack_cyc);
        int n;
        n = 0;
        mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb; mem_valid = 1'b1;
        ack_cyc = -1; rdata = 32'h0;
        while (ack_cyc < 0 && n < 300) begin
            @(negedge clk);
            n++;
            if (mem_ready) begin
                rdata = mem_rdata;
                ack_cyc = cyc;
            end
        end
        @(posedge clk); #1;
        mem_valid = 1'b0; mem_wstrb = 4'h0;
        tests++;
        if (ack_cyc < 0) begin
            fails++;
            $display("FAIL bus_ack addr=%h: got no mem_ready, expected ack within 300 cycles", addr);
        end
    endtask

    task automatic wr(input logic [31:0] a, d);
        logic [31:0] r; int c;
        bus_access(a, d, 4'hF, r, c);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output int c);
        bus_access(a, 32'h0, 4'h0, d, c);
    endtask

    task automatic do_start(input logic [31:0] ang);
        wr(A_IN, ang);
`ifndef CORDIC_CTRL_AUTOSTART_EN
        wr(A_CTRL, 32'h1);
`endif
    endtask

    task automatic clear_status();
        wr(A_STAT, 32'h1E);
        m_done = 0; m_ovr = 0; m_rerr = 0; m_to = 0;
    endtask

    task automatic test_reset();
        logic [31:0] addrs [4];
        logic [31:0] r; int c;
        addrs = '{A_STAT, A_IN, A_COS, A_SIN};
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (mem_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", mem_ready); end
        tests++; if (mem_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h expected 0", mem_rdata); end
        tests++; if (core_start !== 1'b0) begin fails++; $display("FAIL reset_start: got %b expected 0", core_start); end
        tests++; if (core_angle !== 32'h0) begin fails++; $display("FAIL reset_angle: got %h expected 0", core_angle); end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd(addrs[i], r, c);
            tests++; if (r !== 32'h0) begin fails++; $display("FAIL reset_reg %h: got %h expected 0", addrs[i], r); end
        end
    endtask

    task automatic test_sel();
        mem_addr = A_COS; #1;
        tests++; if (sel !== 1'b1) begin fails++; $display("FAIL sel_hit: got %b expected 1", sel); end
        mem_addr = BASE + 32'h100; #1;
        tests++; if (sel !== 1'b0) begin fails++; $display("FAIL sel_above: got %b expected 0", sel); end
        mem_addr = 32'h7000_001C; #1;
        tests++; if (sel !== 1'b0) begin fails++; $display("FAIL sel_other: got %b expected 0", sel); end
        mem_addr = 32'h0;
    endtask

    task automatic test_compute(input int n);
        logic [31:0] ang, r; int c, l, s0;
        clear_status();
        for (int i = 0; i < n; i++) begin
            ang = i == 0 ? 32'h005A_0000 : i == 1 ? 32'hFFA6_0000 : i == 2 ? 32'h002D_0000 : rand_in();
            stub_delay = i == 2 ? 20 : $urandom_range(2, 30);
            stub_cos = i == 2 ? 32'h0000_B505 : $urandom;
            stub_sin = i == 2 ? 32'h0000_B505 : $urandom;
            s0 = starts;
            do_start(ang);
            @(negedge clk);
            l = cyc;
            tests++; if (core_start !== 1'b1 || core_angle !== ang) begin fails++; $display("FAIL compute_launch: got start=%b angle=%h expected 1 %h", core_start, core_angle, ang); end
            m_in = ang; m_done = 1; m_cos = stub_cos; m_sin = stub_sin;
            rd(A_COS, r, c);
            tests++; if (r !== m_cos) begin fails++; $display("FAIL compute_cos: got %h expected %h", r, m_cos); end
            tests++; if (c !== l + stub_delay + 1) begin fails++; $display("FAIL compute_latency: got cycle %0d expected %0d", c, l + stub_delay + 1); end
            rd(A_SIN, r, c);
            tests++; if (r !== m_sin) begin fails++; $display("FAIL compute_sin: got %h expected %h", r, m_sin); end
            rd(A_STAT, r, c);
            tests++; if (r !== exp_reg(8'h04)) begin fails++; $display("FAIL compute_status: got %h expected %h", r, exp_reg(8'h04)); end
            tests++; if (starts - s0 !== 1) begin fails++; $display("FAIL compute_pulses: got %0d expected 1", starts - s0); end
        end
    endtask

    task automatic test_range();
        logic [31:0] ang, r; int c, s0;
        clear_status();
        for (int i = 0; i < 5; i++) begin
            ang = i == 0 ? 32'h005B_0000 : i == 1 ? 32'h005A_0001 : i == 2 ? 32'hFFA5_FFFF :
                  $urandom_range(0, 1) ? 32'h005A_0001 + 32'($urandom_range(0, 32'h7000_0000))
                                       : 32'hFFA5_FFFF - 32'($urandom_range(0, 32'h7000_0000));
            if (in_range(ang)) $display("note: generated angle %h unexpectedly in range", ang);
            s0 = starts;
            do_start(ang);
            repeat (4) @(negedge clk);
            m_in = ang; m_rerr = 1;
            tests++; if (starts !== s0) begin fails++; $display("FAIL range_pulse: got %0d pulses expected 0 for %h", starts - s0, ang); end
            rd(A_STAT, r, c);
            tests++; if (r !== exp_reg(8'h04)) begin fails++; $display("FAIL range_status: got %h expected %h", r, exp_reg(8'h04)); end
            wr(A_STAT, 32'h8);
            m_rerr = 0;
            rd(A_STAT, r, c);
            tests++; if (r !== exp_reg(8'h04)) begin fails++; $display("FAIL range_clear: got %h expected %h", r, exp_reg(8'h04)); end
        end
    endtask

    task automatic test_overrun();
        logic [31:0] ang, r; int c, s0;
        clear_status();
        ang = rand_in();
        stub_delay = 20; stub_cos = $urandom; stub_sin = $urandom;
        s0 = starts;
        do_start(ang);
        m_in = ang; m_done = 0;
        wr(A_IN, 32'h0010_0000);
        wr(A_CTRL, 32'h1);
        m_ovr = 1;
        rd(A_IN, r, c);
        tests++; if (r !== m_in) begin fails++; $display("FAIL ovr_input: got %h expected %h", r, m_in); end
        rd(A_STAT, r, c);
        tests++; if (r !== (exp_reg(8'h04) | 32'h1)) begin fails++; $display("FAIL ovr_busy_status: got %h expected %h", r, exp_reg(8'h04) | 32'h1); end
        rd(A_COS, r, c);
        m_cos = stub_cos; m_sin = stub_sin; m_done = 1;
        tests++; if (r !== m_cos) begin fails++; $display("FAIL ovr_cos: got %h expected %h", r, m_cos); end
        tests++; if (starts - s0 !== 1) begin fails++; $display("FAIL ovr_pulses: got %0d expected 1", starts - s0); end
        rd(A_STAT, r, c);
        tests++; if (r !== exp_reg(8'h04)) begin fails++; $display("FAIL ovr_status: got %h expected %h", r, exp_reg(8'h04)); end
    endtask

    task automatic test_timeout();
        logic [31:0] r; int c, l;
        clear_status();
        stub_delay = 0;
        m_in = rand_in();
        do_start(m_in);
        @(negedge clk);
        l = cyc;
        tests++; if (core_start !== 1'b1) begin fails++; $display("FAIL tmo_launch: got %b expected 1", core_start); end
        rd(A_COS, r, c);
        m_to = 1; m_cos = 32'hDEAD_BEEF; m_sin = 32'hDEAD_BEEF;
        tests++; if (r !== m_cos) begin fails++; $display("FAIL tmo_cos: got %h expected %h", r, m_cos); end
        tests++; if (c !== l + TMO + 1) begin fails++; $display("FAIL tmo_latency: got cycle %0d expected %0d", c, l + TMO + 1); end
        rd(A_SIN, r, c);
        tests++; if (r !== m_sin) begin fails++; $display("FAIL tmo_sin: got %h expected %h", r, m_sin); end
        rd(A_STAT, r, c);
        tests++; if (r !== exp_reg(8'h04)) begin fails++; $display("FAIL tmo_status: got %h expected %h", r, exp_reg(8'h04)); end
        wr(A_STAT, 32'h10);
        m_to = 0;
        rd(A_STAT, r, c);
        tests++; if (r !== exp_reg(8'h04)) begin fails++; $display("FAIL tmo_clear: got %h expected %h", r, exp_reg(8'h04)); end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] r; int c, acks;
        clear_status();
        stub_delay = 15; stub_cos = $urandom | 32'h1; stub_sin = $urandom | 32'h1;
        do_start(rand_in());
        @(negedge clk);
        mem_addr = A_COS; mem_wstrb = 4'h0; mem_valid = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1; mem_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tests++; if (mem_ready !== 1'b0 || mem_rdata !== 32'h0) begin fails++; $display("FAIL rst_bus: got ready=%b rdata=%h expected 0 0", mem_ready, mem_rdata); end
        tests++; if (core_start !== 1'b0 || core_angle !== 32'h0) begin fails++; $display("FAIL rst_core: got start=%b angle=%h expected 0 0", core_start, core_angle); end
        acks = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_ready) acks++;
        end
        tests++; if (acks !== 0) begin fails++; $display("FAIL rst_dropped: got %0d acks expected 0", acks); end
        m_in = 0; m_cos = 0; m_sin = 0; m_done = 0; m_ovr = 0; m_rerr = 0; m_to = 0;
        rd(A_COS, r, c);
        tests++; if (r !== m_cos) begin fails++; $display("FAIL rst_cos: got %h expected %h", r, m_cos); end
        rd(A_STAT, r, c);
        tests++; if (r !== exp_reg(8'h04)) begin fails++; $display("FAIL rst_status: got %h expected %h", r, exp_reg(8'h04)); end
        rd(A_IN, r, c);
        tests++; if (r !== m_in) begin fails++; $display("FAIL rst_input: got %h expected %h", r, m_in); end
    endtask

    task automatic test_input_write();
        logic [31:0] ang, r; int c, s0;
        ang = rand_in();
        stub_delay = 6; stub_cos = $urandom; stub_sin = $urandom;
        s0 = starts;
        wr(A_IN, ang);
`ifndef CORDIC_CTRL_AUTOSTART_EN
        repeat (5) @(negedge clk);
        tests++; if (starts !== s0) begin fails++; $display("FAIL inwr_nostart: got %0d pulses expected 0", starts - s0); end
        wr(A_CTRL, 32'h0);
        repeat (3) @(negedge clk);
        tests++; if (starts !== s0) begin fails++; $display("FAIL ctrl_zero: got %0d pulses expected 0", starts - s0); end
        wr(A_CTRL, 32'h1);
`endif
        @(negedge clk);
        tests++; if (core_start !== 1'b1 || core_angle !== ang) begin fails++; $display("FAIL inwr_launch: got start=%b angle=%h expected 1 %h", core_start, core_angle, ang); end
        m_in = ang; m_cos = stub_cos; m_sin = stub_sin; m_done = 1;
        rd(A_COS, r, c);
        tests++; if (r !== m_cos) begin fails++; $display("FAIL inwr_cos: got %h expected %h", r, m_cos); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] offs [8];
        logic [7:0] o;
        logic [31:0] ang, r; int c;
        offs = '{8'h00, 8'h04, 8'h08, 8'h18, 8'h1C, 8'h20, 8'h24, 8'hFC};
        ang = rand_in();
        stub_delay = 3; stub_cos = $urandom; stub_sin = $urandom;
        bus_access(A_IN, ang, 4'b0100, r, c);
        m_in = ang;
`ifdef CORDIC_CTRL_AUTOSTART_EN
        m_cos = stub_cos; m_sin = stub_sin; m_done = 1;
`endif
        rd(A_IN, r, c);
        tests++; if (r !== m_in) begin fails++; $display("FAIL strobe_input: got %h expected %h", r, m_in); end
        rd(A_COS, r, c);
        tests++; if (r !== m_cos) begin fails++; $display("FAIL strobe_cos: got %h expected %h", r, m_cos); end
        wr(A_COS, $urandom);
        wr(BASE + 32'h08, $urandom);
        for (int i = 0; i < 12; i++) begin
            o = offs[$urandom_range(0, 7)];
            rd(BASE + {24'h0, o}, r, c);
            tests++; if (r !== exp_reg(o)) begin fails++; $display("FAIL b2b_read off=%h: got %h expected %h", o, r, exp_reg(o)); end
        end
        tests++; if (ready_violations !== 0) begin fails++; $display("FAIL ready_consecutive: got %0d occurrences expected 0", ready_violations); end
    endtask

    initial begin
        test_reset();
        test_sel();
        test_compute(7);
        test_range();
        test_overrun();
        test_timeout();
        test_reset_mid_wait();
        test_input_write();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cordic_mmio_ctrl.md
# cordic_mmio_ctrl

Memory-mapped controller that sequences the iterative CORDIC core on behalf of the PicoRV32 CPU. Decodes native-bus accesses in the 0xF000_0000 peripheral window, latches the input angle, launches the core with a start/done handshake, captures cos/sin results, and stalls CPU result reads until the computation completes or times out. Sits between the SoC bus interconnect and the CORDIC datapath inside `top`.

## Interface
- `BASE_ADDR`, 32'hF000_0000: window base; decode is `mem_addr[31:8] == BASE_ADDR[31:8]`.
- `TIMEOUT`, 256: max cycles in WAIT before abort; legal 16..65535.
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `mem_valid` in 1: CPU request, held until `mem_ready`.
- `mem_addr` in 32: byte address.
- `mem_wdata` in 32: write data.
- `mem_wstrb` in 4: nonzero = write; partial strobes are treated as full-word writes.
- `mem_ready` out 1: one-cycle acknowledge.
- `mem_rdata` out 32: read data, valid while `mem_ready` is high, 0 otherwise.
- `sel` out 1: combinational window hit, for the interconnect read mux.
- `core_start` out 1: one-cycle launch pulse.
- `core_angle` out 32: Q16.16 degrees, stable from `core_start` until `core_done`.
- `core_done` in 1: one-cycle completion pulse.
- `core_cos`, `core_sin` in 32 each: Q16.16 results, valid with `core_done`.

## Operation
- Register map (offsets):
  - 0x00 CTRL: W bit0 = start (self-clearing); R = 0.
  - 0x04 STATUS: R bit0 = busy, bit1 = done (sticky), bit2 = ovr, bit3 = range_err, bit4 = timeout. A write of 1 clears bits 1..4 (W1C).
  - 0x18 INPUT_DATA: RW angle.
  - 0x1C COS, 0x20 SIN: R results.
  - Other offsets: read 0, writes ignored, acknowledged normally.
- Sequencer FSM:
  - IDLE: on a start request, go to LAUNCH.
    - If INPUT_DATA is outside [0xFFA6_0000, 0x005A_0000] (signed ±90°), set range_err and stay in IDLE. No pulse is issued.
  - LAUNCH: drive `core_start`=1 for exactly one cycle, clear done, then go to WAIT.
  - WAIT: on `core_done`, capture COS/SIN, set done, and go to IDLE.
  - WAIT, on timeout: when the cycle counter reaches TIMEOUT, set timeout, load COS=SIN=0xDEAD_BEEF, and go to IDLE.
- busy = (state != IDLE).
- A start request or INPUT_DATA write while busy is ignored; ovr is set and INPUT_DATA is unchanged.
- `core_done` while in IDLE or LAUNCH is ignored.
- Bus rules:
  - Reads of COS/SIN while busy hold `mem_ready` low until the FSM returns to IDLE, then acknowledge with the new value.
  - All other accesses acknowledge one cycle after `mem_valid & sel`.
  - `mem_ready` never asserts on two consecutive cycles.
- Arithmetic: no computation in the controller. The range check is a signed 32-bit compare.

## Timing
- Reset values: `mem_ready`=0, `mem_rdata`=0, `core_start`=0, `core_angle`=0, INPUT/COS/SIN=0, STATUS=0, FSM=IDLE, counter=0.
- Start write acknowledged in cycle N: LAUNCH in N+1 (`core_start` high), WAIT from N+2.
- `core_done` in cycle M: COS/SIN/done visible from M+1. A stalled read acknowledges in M+1 with the new data.
- Timeout: abort in the cycle where counter == TIMEOUT (counter counts WAIT cycles from 1).
- Same-cycle STATUS W1C and a hardware set of the same bit: set wins.
- `reset` mid-WAIT:
  - Returns to IDLE next edge with all reset values.
  - A stalled read is dropped (`mem_ready` stays 0).
  - A later `core_done` is ignored.

## Configuration
- `CORDIC_CTRL_AUTOSTART_EN` defined: an accepted INPUT_DATA write in IDLE also acts as a start request. The FSM enters LAUNCH the cycle after the acknowledge, using the newly written angle. CTRL.start still works.
- Undefined: INPUT_DATA writes only store the angle; only CTRL.start launches.

## Test plan
- Autostart on, write 0x002D_0000 to 0xF000_0018. Core stub returns done after 20 cycles with cos=sin=0x0000_B505.
  - Expect one `core_start` pulse with `core_angle`=0x002D_0000.
  - A read of 0x1C stalls, then returns 0x0000_B505.
  - STATUS reads 0x2.
- Write 0x005B_0000, then start.
  - Expect no `core_start`.
  - STATUS=0x8.
  - Writing 0x8 to STATUS clears it to 0.
- While busy, write 0x0010_0000 to INPUT_DATA.
  - Expect ovr set.
  - INPUT_DATA keeps the previous angle.
  - Only one `core_start` pulse.
- TIMEOUT=64, stub never pulses done.
  - Stalled read returns 0xDEAD_BEEF exactly 64 WAIT cycles after LAUNCH.
  - STATUS=0x10.
- Assert `reset` 5 cycles into WAIT.
  - All outputs and registers are 0 next cycle.
  - A late `core_done` leaves COS=0 and done=0.
- Autostart off: INPUT_DATA write produces no `core_start`. A subsequent CTRL write of 0x1 launches it.
